// File: rtl/fma_pkg.sv
// fma_pkg: shared widths, encodings and FSM states for the FMA issue controller
package fma_pkg;
    localparam int FP_W = 32;
    localparam logic [1:0] RND_NEAREST = 2'b00;
    localparam logic [1:0] RND_ZERO    = 2'b01;
    localparam logic [1:0] RND_POS     = 2'b10;
    localparam logic [1:0] RND_NEG     = 2'b11;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    typedef enum logic {IDLE, DRIVE} state_t;
endpackage

// File: rtl/fma_res_fifo.sv
// fma_res_fifo: synchronous result FIFO with push/pop/flush and occupancy count
// Ports: clk, rst_n (async, active low), flush (sync empty), push/wdata (tail write),
//        pop (head advance), rdata (head, 0 when empty), valid (non-empty), count (occupancy).
module fma_res_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          valid,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop && cnt_q != '0;
        do_push = push && (cnt_q != CW'(DEPTH) || do_pop);
        wr_d    = flush ? '0 : do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = flush ? '0 : do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = flush ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q] <= wdata;
    end

    assign valid = cnt_q != '0;
    assign count = cnt_q;
    // Gate the head so an empty FIFO (including right after reset) reads 0.
    assign rdata = valid ? mem_q[rd_q] : '0;
endmodule

// File: rtl/fma_issue_ctrl.sv
// fma_issue_ctrl: issues operand sets to the combinational FMA datapath and queues its results
// Ports: clk, rst_n (async, active low), flush (sync abort);
//        in_* with in_valid/in_ready: operand set intake;
//        fma_*: registered datapath operands, fma_out: datapath result;
//        res_data with res_valid/res_ready: result drain; busy, res_count: status.
module fma_issue_ctrl
    import fma_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_a,
    input  logic [FP_W-1:0] in_b,
    input  logic [FP_W-1:0] in_c,
    input  logic [FP_W-1:0] in_d,
    input  logic            in_op,
    input  logic [1:0]      in_rnd,
    output logic [FP_W-1:0] fma_a,
    output logic [FP_W-1:0] fma_b,
    output logic [FP_W-1:0] fma_c,
    output logic [FP_W-1:0] fma_d,
    output logic            fma_op,
    output logic [1:0]      fma_rnd,
    input  logic [FP_W-1:0] fma_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [FP_W-1:0] res_data,
    output logic            busy,
    output logic [CW-1:0]   res_count
);
    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [FP_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic            op_q, op_d;
    logic [1:0]      rnd_q, rnd_d;
    logic            accept, done;

    always_comb begin
        in_ready = state_q == IDLE && res_count < CW'(FIFO_DEPTH) && !flush;
        accept   = in_valid && in_ready;
        // A result due on a flush edge is dropped rather than pushed.
        done     = state_q == DRIVE && cnt_q == '0 && !flush;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = DRIVE;
            cnt_d   = 4'(SETTLE_CYC - 1);
        end else if (state_q == DRIVE) begin
            state_d = cnt_q == '0 ? IDLE : DRIVE;
            cnt_d   = cnt_q == '0 ? '0 : cnt_q - 4'd1;
        end
        a_d   = accept ? in_a : a_q;
        b_d   = accept ? in_b : b_q;
        c_d   = accept ? in_c : c_q;
        d_d   = accept ? in_d : d_q;
        op_d  = accept ? in_op : op_q;
        rnd_d = accept ? in_rnd : rnd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            op_q    <= 1'b0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            op_q    <= op_d;
            rnd_q   <= rnd_d;
        end
    end

    fma_res_fifo #(.W(FP_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (done),
        .wdata (fma_out),
        .pop   (res_ready),
        .rdata (res_data),
        .valid (res_valid),
        .count (res_count)
    );

    assign fma_a   = a_q;
    assign fma_b   = b_q;
    assign fma_c   = c_q;
    assign fma_d   = d_q;
    assign fma_op  = op_q;
    assign fma_rnd = rnd_q;
    assign busy    = state_q == DRIVE;
endmodule

// File: doc/fma_issue_ctrl.md
Name: fma_issue_ctrl

Overview:
Sequential front end and back end for the combinational FP32 fused multiply-add datapath (A*B ± C*D).
- Accepts operand sets over a valid/ready handshake.
- Registers them and drives the datapath's operand inputs, holding them stable for a programmable settle time.
- Samples the datapath result and queues it in a small result FIFO, which is drained over a second valid/ready handshake.
- Sits between the coprocessor command decoder and the FMA datapath. This block is the initiator/collector at the far end of the datapath's operand/result interface.

Parameters:
SETTLE_CYC, 2, number of clock cycles the operand registers are held before the datapath result is sampled; legal range 1..15.
FIFO_DEPTH, 4, result FIFO entries; power of two, ≥2.

Ports:
clk  in  1  clock, rising-edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous abort: drop the in-flight operation and empty the FIFO.
in_valid  in  1  operand set valid.
in_ready  out  1  block can accept an operand set.
in_a, in_b, in_c, in_d  in  32 each  FP32 operands.
in_op  in  1  add/subtract select, passed to the datapath.
in_rnd  in  2  rounding mode, passed to the datapath.
fma_a, fma_b, fma_c, fma_d  out  32 each  registered operands to the datapath.
fma_op  out  1  registered op to the datapath.
fma_rnd  out  2  registered rounding mode to the datapath.
fma_out  in  32  combinational datapath result.
res_valid  out  1  FIFO non-empty.
res_ready  in  1  consumer accepts the head entry.
res_data  out  32  FIFO head.
busy  out  1  operation in flight (state DRIVE).
res_count  out  clog2(FIFO_DEPTH+1)  FIFO occupancy.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following are 0: state IDLE, settle counter, fma_* registers, FIFO pointers and count, res_valid, busy. res_data reads 0.
- Clocking: one clock domain; every register updates on the rising edge of clk.
- FSM states: IDLE, DRIVE.
- in_ready = (state==IDLE) && (res_count < FIFO_DEPTH) && !flush. It is combinational from registered state and flush only, never from in_valid.
- Accept: an edge with in_valid && in_ready.
  - Loads fma_* from in_*.
  - Counter ← SETTLE_CYC-1.
  - State → DRIVE.
- DRIVE:
  - fma_* held constant.
  - Counter decrements each edge.
  - At the edge where counter==0: fma_out is written to the FIFO tail and state → IDLE.
- Latency: if accept occurs at edge k, the result is written at edge k+SETTLE_CYC. res_valid is high after that edge if the FIFO was empty. in_ready re-asserts in the same cycle.
- Throughput: one operation per SETTLE_CYC+1 cycles.
- fma_* keep their last values after the operation completes. They change only on accept or reset.
- Operand values and in_valid are ignored outside an accept edge.
- FIFO pop: an edge with res_valid && res_ready advances the head.
- FIFO push and pop in the same edge: count unchanged, data order preserved.
- Overflow is impossible by construction: at accept the FIFO has a free slot, and only one operation is in flight.
- Pop when empty: no effect.
- Pointers wrap modulo FIFO_DEPTH.
- res_data is the registered head entry, valid whenever res_valid is high. It is stable while res_valid && !res_ready.
- flush (priority over accept, push and pop):
  - Next state IDLE, counter 0.
  - FIFO emptied (count 0, pointers 0).
  - fma_* retain their values.
  - A result due on the same edge is discarded.
- Reset mid-operation: immediate return to reset state. The in-flight result and all queued results are lost.
- busy = (state==DRIVE).

Decomposition:
- Shared package fma_pkg holds:
  - FP_W = 32.
  - Rounding-mode constants: RND_NEAREST=2'b00, RND_ZERO=2'b01, RND_POS=2'b10, RND_NEG=2'b11.
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - FSM state enum {IDLE, DRIVE}.
- One sub-module: fma_res_fifo, a synchronous FIFO parameterized by width and depth with push/pop/count/flush.
- The FSM and operand registers live in fma_issue_ctrl.

Test Plan:
The bench stub drives fma_out = fma_a ^ fma_d (combinational).
1. Single op, SETTLE_CYC=2: accept A=0x3F000000, D=0x3E800000 at edge k → res_valid rises after edge k+2, res_data=0x01800000; in_ready low during DRIVE, high again after edge k+2.
2. Back-to-back: in_valid held high for 3 sets (A=1,2,3; D=0) with res_ready=1 → results 1,2,3 in order, accepts spaced exactly 3 cycles apart.
3. FIFO full, FIFO_DEPTH=4, res_ready=0: 4 ops complete → res_count=4, in_ready stays 0. One pop → in_ready=1 next cycle, and the 5th op is accepted.
4. Simultaneous push/pop: count=2, a result written while res_ready=1 → res_count stays 2, head advances to the next entry.
5. flush asserted during DRIVE with 2 queued entries → next cycle state IDLE, res_count=0, res_valid=0; the in-flight result never appears.
6. rst_n pulsed low mid-DRIVE (asynchronous, between edges) → res_valid, busy and fma_a drop to 0 immediately; after release, a normal op completes with latency SETTLE_CYC.
